// File: rtl/channel_cmd_decoder.sv
// Command decoder: parses framed SPI bytes into timing-register loads, pixel-RAM lane writes and refresh strobes.
// Optional feature: define AUTO_REFRESH_EN to pulse ram_wr_done_o when a DATA frame that wrote at least once ends.
module channel_cmd_decoder #(
  parameter logic [7:0] CMD_CONF_WR = 8'h2A,
  parameter logic [7:0] CMD_ADDR_WR = 8'h2B,
  parameter logic [7:0] CMD_DATA_WR = 8'h2C,
  parameter logic [7:0] CMD_REFRESH = 8'h2D
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_byte_vld_i,
  input  logic [7:0] spi_byte_data_i,
  output logic [7:0] reg_t0h_time_o,
  output logic [8:0] reg_t0s_time_o,
  output logic [7:0] reg_t1h_time_o,
  output logic [8:0] reg_t1s_time_o,
  output logic       ram_wr_en_o,
  output logic       ram_wr_done_o,
  output logic [7:0] ram_wr_addr_o,
  output logic [7:0] ram_wr_data_o,
  output logic [3:0] ram_wr_byte_en_o
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LANE_W = 2;

  localparam logic [ST_W-1:0] IDLE    = 3'd0;
  localparam logic [ST_W-1:0] CONF    = 3'd1;
  localparam logic [ST_W-1:0] ADDR    = 3'd2;
  localparam logic [ST_W-1:0] DATA    = 3'd3;
  localparam logic [ST_W-1:0] DISCARD = 3'd4;

  logic [ST_W-1:0]   state, state_nxt;
  logic [CNT_W-1:0]  conf_cnt, conf_cnt_nxt;
  logic [LANE_W-1:0] lane, lane_nxt;
  logic [7:0]        addr_cnt, addr_cnt_nxt;

  logic [7:0] t0h_nxt, t1h_nxt;
  logic [8:0] t0s_nxt, t1s_nxt;
  logic       wr_en_nxt, wr_done_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;
  logic [3:0] wr_byte_en_nxt;

`ifdef AUTO_REFRESH_EN
  logic wrote, wrote_nxt;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      conf_cnt         <= '0;
      lane             <= 2'd3;
      addr_cnt         <= '0;
      reg_t0h_time_o   <= 8'h10;
      reg_t0s_time_o   <= 9'h040;
      reg_t1h_time_o   <= 8'h30;
      reg_t1s_time_o   <= 9'h040;
      ram_wr_en_o      <= 1'b0;
      ram_wr_done_o    <= 1'b0;
      ram_wr_addr_o    <= '0;
      ram_wr_data_o    <= '0;
      ram_wr_byte_en_o <= '0;
`ifdef AUTO_REFRESH_EN
      wrote            <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      conf_cnt         <= conf_cnt_nxt;
      lane             <= lane_nxt;
      addr_cnt         <= addr_cnt_nxt;
      reg_t0h_time_o   <= t0h_nxt;
      reg_t0s_time_o   <= t0s_nxt;
      reg_t1h_time_o   <= t1h_nxt;
      reg_t1s_time_o   <= t1s_nxt;
      ram_wr_en_o      <= wr_en_nxt;
      ram_wr_done_o    <= wr_done_nxt;
      ram_wr_addr_o    <= wr_addr_nxt;
      ram_wr_data_o    <= wr_data_nxt;
      ram_wr_byte_en_o <= wr_byte_en_nxt;
`ifdef AUTO_REFRESH_EN
      wrote            <= wrote_nxt;
`endif
    end
  end

  // Next-state and next-output decode; frame end overrides any byte in the same cycle
  always_comb begin
    state_nxt      = state;
    conf_cnt_nxt   = conf_cnt;
    lane_nxt       = lane;
    addr_cnt_nxt   = addr_cnt;
    t0h_nxt        = reg_t0h_time_o;
    t0s_nxt        = reg_t0s_time_o;
    t1h_nxt        = reg_t1h_time_o;
    t1s_nxt        = reg_t1s_time_o;
    wr_en_nxt      = 1'b0;
    wr_done_nxt    = 1'b0;
    wr_addr_nxt    = ram_wr_addr_o;
    wr_data_nxt    = ram_wr_data_o;
    wr_byte_en_nxt = ram_wr_byte_en_o;
`ifdef AUTO_REFRESH_EN
    wrote_nxt      = wrote;
`endif

    if (spi_cs_n_i) begin
      state_nxt    = IDLE;
      lane_nxt     = 2'd3;
      conf_cnt_nxt = '0;
`ifdef AUTO_REFRESH_EN
      if (state == DATA && wrote) wr_done_nxt = 1'b1;
      wrote_nxt = 1'b0;
`endif
    end else if (spi_byte_vld_i) begin
      case (state)
        IDLE: begin
          if (spi_byte_data_i == CMD_CONF_WR) begin
            state_nxt    = CONF;
            conf_cnt_nxt = '0;
          end else if (spi_byte_data_i == CMD_ADDR_WR) begin
            state_nxt = ADDR;
          end else if (spi_byte_data_i == CMD_DATA_WR) begin
            state_nxt = DATA;
            lane_nxt  = 2'd3;
          end else if (spi_byte_data_i == CMD_REFRESH) begin
            state_nxt   = DISCARD;
            wr_done_nxt = 1'b1;
          end else begin
            state_nxt = DISCARD;
          end
        end
        CONF: begin
          case (conf_cnt)
            3'd0:    t0h_nxt = spi_byte_data_i;
            3'd1:    t0s_nxt = {spi_byte_data_i[0], reg_t0s_time_o[7:0]};
            3'd2:    t0s_nxt = {reg_t0s_time_o[8], spi_byte_data_i};
            3'd3:    t1h_nxt = spi_byte_data_i;
            3'd4:    t1s_nxt = {spi_byte_data_i[0], reg_t1s_time_o[7:0]};
            default: t1s_nxt = {reg_t1s_time_o[8], spi_byte_data_i};
          endcase
          conf_cnt_nxt = conf_cnt + CNT_W'(1);
          if (conf_cnt == 3'd5) state_nxt = DISCARD;
        end
        ADDR: begin
          addr_cnt_nxt = spi_byte_data_i;
          state_nxt    = DISCARD;
        end
        DATA: begin
          wr_en_nxt      = 1'b1;
          wr_addr_nxt    = addr_cnt;
          wr_data_nxt    = spi_byte_data_i;
          wr_byte_en_nxt = 4'b0001 << lane;
`ifdef AUTO_REFRESH_EN
          wrote_nxt      = 1'b1;
`endif
          if (lane == 2'd0) begin
            lane_nxt     = 2'd3;
            addr_cnt_nxt = addr_cnt + 8'd1;
          end else begin
            lane_nxt = lane - LANE_W'(1);
          end
        end
        default: state_nxt = DISCARD;
      endcase
    end
  end

endmodule
